// File: rtl/barramento_dados_pkg.sv
// Shared definitions for the nRisc data bus: MMIO register offsets and
// the bit layout of the FIFO status register.
package barramento_dados_pkg;

    localparam logic [7:0] OFF_FIFO    = 8'd0;
    localparam logic [7:0] OFF_COUNT   = 8'd1;
    localparam logic [7:0] OFF_TICK    = 8'd2;
    localparam logic [7:0] OFF_CLRFLAG = 8'd3;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_OVF   = 2;

endpackage

// File: rtl/barramento_dados_fila_saida.sv
// Output FIFO: synchronous push/pop with full/empty/count and async reset.
// The head is taken straight from registered storage, so it only moves on an edge.
module fila_saida #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           dataIn,
    output logic [WIDTH-1:0]           dataOut,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign doPop   = pop && !empty;
    // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
    assign doPush  = push && (!full || doPop);
    assign dataOut = mem[rdPtr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (doPush) begin
                mem[wrPtr] <= dataIn;
                wrPtr      <= wrPtr + PW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PW'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/barramento_dados.sv
// Data-side bus unit for the nRisc core: byte RAM below MMIO_BASE, and an
// I/O window holding the output FIFO, a free-running cycle counter and status.
module barramento_dados
    import barramento_dados_pkg::*;
#(
    parameter logic [7:0] MMIO_BASE  = 8'hF0,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] EnderecoDados,
    input  logic [7:0] DadoEscrito,
    input  logic       MemWrite,
    input  logic       MemRead,
    output logic [7:0] DadoLido,
    output logic [7:0] SaidaDado,
    output logic       SaidaValida,
    input  logic       SaidaPronta
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [7:0]    ram [0:int'(MMIO_BASE)-1];
    logic [7:0]    ioOff;
    logic          isIo;
    logic          fifoPush;
    logic          fifoPop;
    logic          fifoFull;
    logic          fifoEmpty;
    logic [CW-1:0] fifoCount;
    logic          overflow;
    logic          ovfSet;
    logic          ovfClear;
    logic          tickLoad;
    logic [7:0]    tickCount;
    logic [7:0]    status;

    assign isIo     = (EnderecoDados >= MMIO_BASE);
    assign ioOff    = EnderecoDados - MMIO_BASE;
    assign fifoPush = MemWrite && isIo && (ioOff == OFF_FIFO);
    assign ovfClear = MemWrite && isIo && (ioOff == OFF_CLRFLAG);
    assign tickLoad = MemWrite && isIo && (ioOff == OFF_TICK);
    assign fifoPop  = SaidaValida && SaidaPronta;
    assign ovfSet   = fifoPush && fifoFull && !fifoPop;

    fila_saida #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) uFila (
        .clock   (Clock),
        .reset   (Reset),
        .push    (fifoPush),
        .pop     (fifoPop),
        .dataIn  (DadoEscrito),
        .dataOut (SaidaDado),
        .full    (fifoFull),
        .empty   (fifoEmpty),
        .count   (fifoCount)
    );

    assign SaidaValida = !fifoEmpty;

    // RAM is not cleared by reset, but a store coincident with reset is dropped.
    always_ff @(posedge Clock) begin
        if (!Reset && MemWrite && !isIo) begin
            ram[EnderecoDados] <= DadoEscrito;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            tickCount <= '0;
        end else if (tickLoad) begin
            tickCount <= '0;
        end else begin
            tickCount <= tickCount + 8'd1;
        end
    end

    // Sticky overflow: a fresh drop in the same cycle beats a clear request.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            overflow <= 1'b0;
        end else if (ovfSet) begin
            overflow <= 1'b1;
        end else if (ovfClear) begin
            overflow <= 1'b0;
        end
    end

    always_comb begin
        status           = '0;
        status[ST_FULL]  = fifoFull;
        status[ST_EMPTY] = fifoEmpty;
        status[ST_OVF]   = overflow;
    end

    always_comb begin
        DadoLido = '0;
        if (MemRead) begin
            if (!isIo) begin
                DadoLido = ram[EnderecoDados];
            end else begin
                case (ioOff)
                    OFF_FIFO:  DadoLido = status;
                    OFF_COUNT: DadoLido = {{(8-CW){1'b0}}, fifoCount};
                    OFF_TICK:  DadoLido = tickCount;
                    default:   DadoLido = '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_barramento_dados.sv
// Directed bench for barramento_dados: RAM, FIFO drain/overflow, cycle
// counter wrap and asynchronous reset, with hand-computed expectations.
module tb_barramento_dados;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [7:0] EnderecoDados;
    logic [7:0] DadoEscrito;
    logic       MemWrite;
    logic       MemRead;
    logic [7:0] DadoLido;
    logic [7:0] SaidaDado;
    logic       SaidaValida;
    logic       SaidaPronta;

    int testsRun    = 0;
    int testsFailed = 0;

    barramento_dados #(
        .MMIO_BASE  (8'hF0),
        .FIFO_DEPTH (4)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .EnderecoDados (EnderecoDados),
        .DadoEscrito   (DadoEscrito),
        .MemWrite      (MemWrite),
        .MemRead       (MemRead),
        .DadoLido      (DadoLido),
        .SaidaDado     (SaidaDado),
        .SaidaValida   (SaidaValida),
        .SaidaPronta   (SaidaPronta)
    );

    always #5 Clock = ~Clock;

    task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] data,
                                 input logic wr, input logic rd);
        EnderecoDados = addr;
        DadoEscrito   = data;
        MemWrite      = wr;
        MemRead       = rd;
        #1;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        Reset         = 1'b1;
        SaidaPronta   = 1'b0;
        EnderecoDados = 8'hF0;
        DadoEscrito   = 8'h00;
        MemWrite      = 1'b0;
        MemRead       = 1'b0;
        #12;
        checkOutput("rst_valid", {7'b0, SaidaValida}, 8'h00);
        checkOutput("rst_dado", SaidaDado, 8'h00);
        checkOutput("rst_lido_noread", DadoLido, 8'h00);
        applyStimulus(8'hF0, 8'h00, 1'b0, 1'b1);
        checkOutput("rst_status", DadoLido, 8'h02);

        // Counter: released between edges, ten edges later it reads 10.
        Reset = 1'b0;
        applyStimulus(8'hF2, 8'h00, 1'b0, 1'b0);
        repeat (10) @(posedge Clock);
        #1;
        applyStimulus(8'hF2, 8'h00, 1'b0, 1'b1);
        checkOutput("tick_10", DadoLido, 8'd10);
        repeat (256) tick();
        checkOutput("tick_wrap", DadoLido, 8'd10);
        applyStimulus(8'hF2, 8'h00, 1'b1, 1'b1);
        tick();
        applyStimulus(8'hF2, 8'h00, 1'b0, 1'b1);
        checkOutput("tick_load0", DadoLido, 8'd0);
        tick();
        checkOutput("tick_after_load", DadoLido, 8'd1);

        // RAM store/load and read-during-write.
        applyStimulus(8'h10, 8'h5A, 1'b1, 1'b0);
        tick();
        applyStimulus(8'h10, 8'h00, 1'b0, 1'b1);
        checkOutput("ram_read", DadoLido, 8'h5A);
        applyStimulus(8'h10, 8'hA5, 1'b1, 1'b1);
        checkOutput("ram_rdw_old", DadoLido, 8'h5A);
        tick();
        applyStimulus(8'h10, 8'h00, 1'b0, 1'b1);
        checkOutput("ram_rdw_new", DadoLido, 8'hA5);
        applyStimulus(8'h10, 8'h00, 1'b0, 1'b0);
        checkOutput("ram_noread", DadoLido, 8'h00);

        // Fill FIFO with sink stalled, then overflow.
        applyStimulus(8'hF0, 8'h11, 1'b1, 1'b0); tick();
        applyStimulus(8'hF0, 8'h22, 1'b1, 1'b0); tick();
        applyStimulus(8'hF0, 8'h33, 1'b1, 1'b0); tick();
        applyStimulus(8'hF0, 8'h44, 1'b1, 1'b0); tick();
        applyStimulus(8'hF1, 8'h00, 1'b0, 1'b1);
        checkOutput("fifo_count4", DadoLido, 8'd4);
        applyStimulus(8'hF0, 8'h00, 1'b0, 1'b1);
        checkOutput("fifo_full_status", DadoLido, 8'h01);
        applyStimulus(8'hF0, 8'h55, 1'b1, 1'b0);
        tick();
        applyStimulus(8'hF0, 8'h00, 1'b0, 1'b1);
        checkOutput("fifo_ovf_status", DadoLido, 8'h05);
        applyStimulus(8'hF1, 8'h00, 1'b0, 1'b1);
        checkOutput("fifo_ovf_count", DadoLido, 8'd4);

        // Drain in order.
        checkOutput("drain_0", SaidaDado, 8'h11);
        SaidaPronta = 1'b1;
        tick();
        checkOutput("drain_1", SaidaDado, 8'h22);
        tick();
        checkOutput("drain_2", SaidaDado, 8'h33);
        tick();
        checkOutput("drain_3", SaidaDado, 8'h44);
        tick();
        checkOutput("drain_valid0", {7'b0, SaidaValida}, 8'h00);
        SaidaPronta = 1'b0;
        applyStimulus(8'hF0, 8'h00, 1'b0, 1'b1);
        checkOutput("drain_status", DadoLido, 8'h06);
        applyStimulus(8'hF3, 8'h00, 1'b1, 1'b0);
        tick();
        applyStimulus(8'hF0, 8'h00, 1'b0, 1'b1);
        checkOutput("clrflag_status", DadoLido, 8'h02);

        // Push into full FIFO while popping: accepted, no overflow.
        applyStimulus(8'hF0, 8'h77, 1'b1, 1'b0); tick();
        applyStimulus(8'hF0, 8'h88, 1'b1, 1'b0); tick();
        applyStimulus(8'hF0, 8'h99, 1'b1, 1'b0); tick();
        applyStimulus(8'hF0, 8'hAA, 1'b1, 1'b0); tick();
        SaidaPronta = 1'b1;
        applyStimulus(8'hF0, 8'h66, 1'b1, 1'b0);
        tick();
        applyStimulus(8'hF1, 8'h00, 1'b0, 1'b1);
        checkOutput("fullpp_count", DadoLido, 8'd4);
        applyStimulus(8'hF0, 8'h00, 1'b0, 1'b1);
        checkOutput("fullpp_status", DadoLido, 8'h01);
        checkOutput("fullpp_head", SaidaDado, 8'h88);
        tick();
        checkOutput("fullpp_99", SaidaDado, 8'h99);
        tick();
        checkOutput("fullpp_AA", SaidaDado, 8'hAA);
        tick();
        checkOutput("fullpp_66", SaidaDado, 8'h66);
        tick();
        checkOutput("fullpp_valid0", {7'b0, SaidaValida}, 8'h00);
        SaidaPronta = 1'b0;

        // Asynchronous reset mid-operation with three entries queued.
        applyStimulus(8'hF0, 8'hB1, 1'b1, 1'b0); tick();
        applyStimulus(8'hF0, 8'hB2, 1'b1, 1'b0); tick();
        applyStimulus(8'hF0, 8'hB3, 1'b1, 1'b0); tick();
        applyStimulus(8'hF1, 8'h00, 1'b0, 1'b1);
        checkOutput("prerst_count", DadoLido, 8'd3);
        checkOutput("prerst_valid", {7'b0, SaidaValida}, 8'h01);
        Reset = 1'b1;
        #1;
        checkOutput("asyncrst_valid", {7'b0, SaidaValida}, 8'h00);
        checkOutput("asyncrst_dado", SaidaDado, 8'h00);
        #1;
        Reset = 1'b0;
        tick();
        checkOutput("postrst_count", DadoLido, 8'd0);
        applyStimulus(8'h10, 8'h00, 1'b0, 1'b1);
        checkOutput("postrst_ram", DadoLido, 8'hA5);

        // Unmapped I/O and cross-region isolation.
        applyStimulus(8'hF7, 8'h00, 1'b0, 1'b1);
        checkOutput("unmapped_read", DadoLido, 8'h00);
        applyStimulus(8'hF7, 8'hEE, 1'b1, 1'b0);
        tick();
        applyStimulus(8'h20, 8'h3C, 1'b1, 1'b0);
        tick();
        applyStimulus(8'hF0, 8'h00, 1'b0, 1'b1);
        checkOutput("unmapped_status", DadoLido, 8'h02);
        applyStimulus(8'hF1, 8'h00, 1'b0, 1'b1);
        checkOutput("ramwr_count", DadoLido, 8'd0);
        applyStimulus(8'h20, 8'h00, 1'b0, 1'b1);
        checkOutput("ram_20", DadoLido, 8'h3C);
        applyStimulus(8'hF1, 8'h00, 1'b0, 1'b0);
        checkOutput("io_noread", DadoLido, 8'h00);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
